// File: rtl/sram_bist_pkg.sv
// Shared definitions for the March C- SRAM BIST controller: FSM states and
// the per-element march table (bit i of each vector describes element i).
package sram_bist_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } bist_state_e;

    localparam int unsigned NUM_ELEMS = 6;
    localparam logic [2:0]  LAST_ELEM = 3'(NUM_ELEMS - 1);

    // Tables are padded to 8 entries so any 3-bit element index is in range.
    // E0 up(w0)  E1 up(r0,w1)  E2 up(r1,w0)  E3 down(r0,w1)  E4 down(r1,w0)  E5 up(r0)
    localparam logic [7:0] ELEM_DOWN      = 8'b0001_1000;
    localparam logic [7:0] ELEM_HAS_READ  = 8'b0011_1110;
    localparam logic [7:0] ELEM_READ_VAL  = 8'b0001_0100;
    localparam logic [7:0] ELEM_HAS_WRITE = 8'b0001_1111;
    localparam logic [7:0] ELEM_WRITE_VAL = 8'b0000_1010;

endpackage

// File: rtl/sram_bist_addr_gen.sv
// Up/down address counter for the march elements. A load picks the direction
// and jumps to that direction's start address; last_o flags the terminal
// address for the direction currently loaded.
module sram_bist_addr_gen #(
    parameter int P_ADDR_WIDTH = 14
) (
    input  logic                    clk_i,
    input  logic                    srst_i,
    input  logic                    load_i,
    input  logic                    load_down_i,
    input  logic                    step_i,
    output logic [P_ADDR_WIDTH-1:0] addr_o,
    output logic                    last_o
);

    localparam logic [P_ADDR_WIDTH-1:0] ADDR_ONE = {{(P_ADDR_WIDTH-1){1'b0}}, 1'b1};

    logic [P_ADDR_WIDTH-1:0] addr_q;
    logic                    down_q;

    // Load has priority over step so an element change never double-moves.
    always_ff @(posedge clk_i) begin
        if (srst_i) begin
            addr_q <= '0;
            down_q <= 1'b0;
        end else if (load_i) begin
            down_q <= load_down_i;
            addr_q <= load_down_i ? '1 : '0;
        end else if (step_i) begin
            addr_q <= down_q ? (addr_q - ADDR_ONE) : (addr_q + ADDR_ONE);
        end
    end

    assign addr_o = addr_q;
    assign last_o = down_q ? (addr_q == '0) : (addr_q == '1);

endmodule

// File: rtl/sram_march_bist_ctrl.sv
// March C- BIST controller for the single-port bit-masked SRAM macro. Drives
// the macro's BIST port group one op per cycle, compares registered read data
// one cycle after each read, and reports pass/fail plus first failing
// address and element.
module sram_march_bist_ctrl #(
    parameter int P_DATA_WIDTH = 24,
    parameter int P_ADDR_WIDTH = 14
) (
    input  logic                    A_CLK,
    input  logic                    A_RST,
    input  logic                    A_START,
    input  logic [P_DATA_WIDTH-1:0] A_DOUT,
    output logic                    A_BIST_EN,
    output logic [P_ADDR_WIDTH-1:0] A_BIST_ADDR,
    output logic [P_DATA_WIDTH-1:0] A_BIST_DIN,
    output logic [P_DATA_WIDTH-1:0] A_BIST_BM,
    output logic                    A_BIST_MEN,
    output logic                    A_BIST_WEN,
    output logic                    A_BIST_REN,
    output logic                    A_BIST_CLK,
    output logic                    A_BUSY,
    output logic                    A_DONE,
    output logic                    A_FAIL,
    output logic [P_ADDR_WIDTH-1:0] A_FAIL_ADDR,
    output logic [2:0]              A_FAIL_ELEM
);

    import sram_bist_pkg::*;

    bist_state_e             state_q;
    logic [2:0]              elem_q;
    logic                    phase_wr_q;   // current op is the write half of its address
    logic                    en_q, men_q, wen_q, ren_q, busy_q, done_q, fail_q;
    logic [P_DATA_WIDTH-1:0] din_q, bm_q;
    logic [P_ADDR_WIDTH-1:0] fail_addr_q;
    logic [2:0]              fail_elem_q;

    // Read-compare pipeline: describes the read issued in the previous cycle.
    logic                    pv_q, pexp_q;
    logic [P_ADDR_WIDTH-1:0] paddr_q;
    logic [2:0]              pelem_q;

    logic [P_ADDR_WIDTH-1:0] cur_addr;
    logic                    addr_last;
    logic                    start_acc, in_run;
    logic                    op_last_at_addr, elem_done, test_done;
    logic [2:0]              nxt_elem;
    logic                    nxt_wr;
    logic                    ag_load, ag_down, ag_step;
    logic                    mismatch;

    assign in_run          = (state_q == ST_RUN);
    assign start_acc       = A_START && ((state_q == ST_IDLE) || (state_q == ST_DONE));
    assign op_last_at_addr = phase_wr_q || !ELEM_HAS_WRITE[elem_q];
    assign elem_done       = op_last_at_addr && addr_last;
    assign test_done       = elem_done && (elem_q == LAST_ELEM);
    assign nxt_elem        = elem_done ? (elem_q + 3'd1) : elem_q;
    assign nxt_wr          = op_last_at_addr ? !ELEM_HAS_READ[nxt_elem] : 1'b1;

    assign ag_load = start_acc || (in_run && elem_done && !test_done);
    assign ag_down = start_acc ? ELEM_DOWN[0] : ELEM_DOWN[nxt_elem];
    assign ag_step = in_run && op_last_at_addr && !addr_last;

    assign mismatch = pv_q && (A_DOUT != {P_DATA_WIDTH{pexp_q}});

    sram_bist_addr_gen #(
        .P_ADDR_WIDTH (P_ADDR_WIDTH)
    ) u_addr_gen (
        .clk_i       (A_CLK),
        .srst_i      (A_RST),
        .load_i      (ag_load),
        .load_down_i (ag_down),
        .step_i      (ag_step),
        .addr_o      (cur_addr),
        .last_o      (addr_last)
    );

    // Control FSM: sequences march ops, registers all macro-side outputs and
    // tracks the sticky pass/fail result.
    always_ff @(posedge A_CLK) begin
        if (A_RST) begin
            state_q     <= ST_IDLE;
            elem_q      <= '0;
            phase_wr_q  <= 1'b0;
            en_q        <= 1'b0;
            men_q       <= 1'b0;
            wen_q       <= 1'b0;
            ren_q       <= 1'b0;
            din_q       <= '0;
            bm_q        <= '0;
            busy_q      <= 1'b0;
            done_q      <= 1'b0;
            fail_q      <= 1'b0;
            fail_addr_q <= '0;
            fail_elem_q <= '0;
            pv_q        <= 1'b0;
            pexp_q      <= 1'b0;
            paddr_q     <= '0;
            pelem_q     <= '0;
        end else begin
            pv_q    <= in_run && ren_q;
            pexp_q  <= ELEM_READ_VAL[elem_q];
            paddr_q <= cur_addr;
            pelem_q <= elem_q;

            if (mismatch) begin
                fail_q <= 1'b1;
                if (!fail_q) begin
                    fail_addr_q <= paddr_q;
                    fail_elem_q <= pelem_q;
                end
            end

            case (state_q)
                ST_IDLE, ST_DONE: begin
                    if (A_START) begin
                        state_q     <= ST_RUN;
                        fail_q      <= 1'b0;
                        fail_addr_q <= '0;
                        fail_elem_q <= '0;
                        done_q      <= 1'b0;
                        busy_q      <= 1'b1;
                        en_q        <= 1'b1;
                        bm_q        <= '1;
                        men_q       <= 1'b1;
                        elem_q      <= '0;
                        phase_wr_q  <= !ELEM_HAS_READ[0];
                        wen_q       <= !ELEM_HAS_READ[0];
                        ren_q       <= ELEM_HAS_READ[0];
                        din_q       <= {P_DATA_WIDTH{ELEM_WRITE_VAL[0]}};
                    end
                end
                ST_RUN: begin
                    if (test_done) begin
                        state_q <= ST_DRAIN;
                        men_q   <= 1'b0;
                        wen_q   <= 1'b0;
                        ren_q   <= 1'b0;
                        din_q   <= '0;
                    end else begin
                        elem_q     <= nxt_elem;
                        phase_wr_q <= nxt_wr;
                        wen_q      <= nxt_wr;
                        ren_q      <= !nxt_wr;
                        din_q      <= nxt_wr ? {P_DATA_WIDTH{ELEM_WRITE_VAL[nxt_elem]}} : '0;
                    end
                end
                ST_DRAIN: begin
                    state_q <= ST_DONE;
                    busy_q  <= 1'b0;
                    done_q  <= 1'b1;
                    en_q    <= 1'b0;
                    bm_q    <= '0;
                end
            endcase
        end
    end

    assign A_BIST_EN   = en_q;
    assign A_BIST_ADDR = cur_addr;
    assign A_BIST_DIN  = din_q;
    assign A_BIST_BM   = bm_q;
    assign A_BIST_MEN  = men_q;
    assign A_BIST_WEN  = wen_q;
    assign A_BIST_REN  = ren_q;
    assign A_BIST_CLK  = A_CLK;
    assign A_BUSY      = busy_q;
    assign A_DONE      = done_q;
    assign A_FAIL      = fail_q;
    assign A_FAIL_ADDR = fail_addr_q;
    assign A_FAIL_ELEM = fail_elem_q;

endmodule
